// File: rtl/ser_fifo.sv
// ser_fifo: buffered 8N1 RS-232 port for the RISC5 I/O space, 16-deep FIFOs each way.
// Ports: clk, rst_n (async, active-low); bus stb/we/addr/data_in/data_out/ack;
//        irq (level); rxd (async serial in); txd (serial out, idle high).

module ser_fifo_buf #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = count[DEPTH_LOG2];
    assign do_pop  = pop & ~empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            if (do_push & ~do_pop)
                count <= count + 1'b1;
            else if (do_pop & ~do_push)
                count <= count - 1'b1;
        end
    end
endmodule

module ser_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(DIV + 1);
    localparam int CW  = DEPTH_LOG2 + 1;
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

    // bus decode; side effects only on the acknowledged edge
    logic act;
    logic wr_data;
    logic wr_ctrl;
    logic rd_pop;
    logic rd_ok;
    logic flush;

    assign act     = stb & ack;
    assign wr_data = act & we & ~addr;
    assign wr_ctrl = act & we & addr;
    // pop only if the value returned one cycle earlier was a real byte
    assign rd_pop  = act & ~we & ~addr & rd_ok;
    assign flush   = wr_ctrl & data_in[3];

    logic unused_ok;
    assign unused_ok = ^data_in[31:8];

    // FIFOs
    logic [7:0]    tx_head;
    logic [7:0]    rx_head;
    logic [7:0]    rx_sh;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_empty;
    logic          tx_full;
    logic          rx_empty;
    logic          rx_full;
    logic          tx_pop;
    logic          rx_push;

    ser_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (wr_data),
        .pop   (tx_pop),
        .wdata (data_in[7:0]),
        .rdata (tx_head),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full)
    );

    ser_fifo_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (rx_push),
        .pop   (rd_pop),
        .wdata (rx_sh),
        .rdata (rx_head),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // control / status
    logic rx_ie;
    logic tx_ie;
    logic rx_overrun;
    logic frame_err;
    logic tx_idle;
    logic rx_bad;
    logic [31:0] status;

    st_t tx_st;

    assign tx_idle = tx_empty & (tx_st == S_IDLE);

    always_comb begin
        status        = '0;
        status[0]     = ~rx_empty;
        status[1]     = ~tx_full;
        status[2]     = rx_overrun;
        status[3]     = frame_err;
        status[4]     = tx_idle;
        status[8]     = rx_ie;
        status[9]     = tx_ie;
        status[20:16] = 5'(rx_count);
        status[28:24] = 5'(tx_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= 1'b0;
            data_out   <= '0;
            rd_ok      <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            ack   <= stb & ~ack;
            rd_ok <= stb & ~ack & ~we & ~addr & ~rx_empty;
            if (stb & ~ack & ~we) begin
                if (addr)
                    data_out <= status;
                else if (rx_empty)
                    data_out <= '0;
                else
                    data_out <= {24'b0, rx_head};
            end else begin
                data_out <= '0;
            end
            if (wr_ctrl) begin
                rx_ie <= data_in[0];
                tx_ie <= data_in[1];
            end
            if (rx_push & rx_full & ~rd_pop)
                rx_overrun <= 1'b1;
            else if (wr_ctrl & data_in[2])
                rx_overrun <= 1'b0;
            if (rx_bad)
                frame_err <= 1'b1;
            else if (wr_ctrl & data_in[2])
                frame_err <= 1'b0;
            irq <= (rx_ie & ~rx_empty) | (tx_ie & (tx_count == '0));
        end
    end

    // transmitter; txd trails the state by one edge
    logic [7:0]    tx_sh;
    logic [TW-1:0] tx_t;
    logic [2:0]    tx_n;

    // reload straight out of the stop bit so back-to-back bytes have no gap
    assign tx_pop = ~tx_empty &
                    ((tx_st == S_IDLE) |
                     ((tx_st == S_STOP) & (tx_t == T_FULL)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st <= S_IDLE;
            txd   <= 1'b1;
            tx_sh <= '0;
            tx_t  <= '0;
            tx_n  <= '0;
        end else begin
            unique case (tx_st)
                S_IDLE: begin
                    txd  <= 1'b1;
                    tx_t <= '0;
                    if (tx_pop) begin
                        tx_sh <= tx_head;
                        tx_st <= S_START;
                    end
                end
                S_START: begin
                    txd <= 1'b0;
                    if (tx_t == T_FULL) begin
                        tx_t  <= '0;
                        tx_n  <= '0;
                        tx_st <= S_DATA;
                    end else begin
                        tx_t <= tx_t + 1'b1;
                    end
                end
                S_DATA: begin
                    txd <= tx_sh[0];
                    if (tx_t == T_FULL) begin
                        tx_t  <= '0;
                        tx_sh <= tx_sh >> 1;
                        tx_n  <= tx_n + 1'b1;
                        if (tx_n == 3'd7)
                            tx_st <= S_STOP;
                    end else begin
                        tx_t <= tx_t + 1'b1;
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (tx_t == T_FULL) begin
                        tx_t <= '0;
                        if (tx_pop) begin
                            tx_sh <= tx_head;
                            tx_st <= S_START;
                        end else begin
                            tx_st <= S_IDLE;
                        end
                    end else begin
                        tx_t <= tx_t + 1'b1;
                    end
                end
            endcase
        end
    end

    // receiver
    logic          rx_s1;
    logic          rx_s;
    logic          rx_q;
    logic          rx_fall;
    logic          rx_wait;
    logic          rx_smp;
    st_t           rx_st;
    logic [TW-1:0] rx_t;
    logic [2:0]    rx_n;

    assign rx_fall = rx_q & ~rx_s;
    assign rx_smp  = (rx_st == S_STOP) & ~rx_wait & (rx_t == T_FULL);
    assign rx_push = rx_smp & rx_s;
    assign rx_bad  = rx_smp & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            rx_st   <= S_IDLE;
            rx_t    <= '0;
            rx_n    <= '0;
            rx_sh   <= '0;
            rx_wait <= 1'b0;
        end else begin
            rx_s1 <= rxd;
            rx_s  <= rx_s1;
            rx_q  <= rx_s;
            unique case (rx_st)
                S_IDLE: begin
                    rx_t <= '0;
                    if (rx_fall)
                        rx_st <= S_START;
                end
                S_START: begin
                    if (rx_t == T_HALF) begin
                        rx_t <= '0;
                        rx_n <= '0;
                        // a glitch that is high again at mid-bit is no start
                        rx_st <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_t <= rx_t + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_t == T_FULL) begin
                        rx_t  <= '0;
                        rx_sh <= {rx_s, rx_sh[7:1]};
                        rx_n  <= rx_n + 1'b1;
                        if (rx_n == 3'd7)
                            rx_st <= S_STOP;
                    end else begin
                        rx_t <= rx_t + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_wait) begin
                        // hold off until the line is idle after a break
                        if (rx_s) begin
                            rx_wait <= 1'b0;
                            rx_st   <= S_IDLE;
                        end
                    end else if (rx_t == T_FULL) begin
                        rx_t <= '0;
                        if (rx_s)
                            rx_st <= S_IDLE;
                        else
                            rx_wait <= 1'b1;
                    end else begin
                        rx_t <= rx_t + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ser_fifo.sv
// tb_ser_fifo: directed bench for ser_fifo at DIV = 10.
// Ports: drives the bus and rxd, samples txd/irq/data_out on falling edges.
module tb_ser_fifo;
    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;
    logic        rxd = 1'b1;
    logic        txd;

    int n_chk = 0;
    int n_fail = 0;

    ser_fifo #(
        .CLK_FREQ   (50000000),
        .BAUD       (5000000),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .irq      (irq),
        .rxd      (rxd),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic w, input logic a, input logic [31:0] d,
                       output logic [31:0] q);
        @(negedge clk);
        stb = 1'b1;
        we = w;
        addr = a;
        data_in = d;
        @(negedge clk);
        chk("bus_ack", {31'b0, ack}, 32'd1);
        q = data_out;
        @(negedge clk);
        stb = 1'b0;
        we = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd(input logic a, output logic [31:0] q);
        bus(1'b0, a, 32'h0, q);
    endtask

    task automatic send(input logic [7:0] b, input bit bad);
        @(negedge clk);
        rxd = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(DIV);
        end
        if (bad) begin
            rxd = 1'b0;
            cyc(2 * DIV);
        end
        rxd = 1'b1;
        cyc(DIV);
    endtask

    initial begin
        logic [31:0] q;
        logic [9:0]  fr;
        int          k;

        // reset
        cyc(1);
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        rd(1'b1, q);
        chk("rst_status", q, 32'h12);

        // transmit 0xA5
        wr(1'b0, 32'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        cyc(1);
        chk("tx_lat_hi", {31'b0, txd}, 32'd1);
        cyc(1);
        chk("tx_lat_lo", {31'b0, txd}, 32'd0);
        cyc(5);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), {31'b0, txd}, {31'b0, fr[i]});
            cyc(DIV);
        end
        cyc(10);
        rd(1'b1, q);
        chk("tx_idle", q, 32'h12);

        // receive two bytes
        send(8'h3C, 1'b0);
        send(8'h81, 1'b0);
        cyc(4);
        rd(1'b1, q);
        chk("rx2_status", q, 32'h0002_0013);
        rd(1'b0, q);
        chk("rx_3c", q, 32'h3C);
        rd(1'b0, q);
        chk("rx_81", q, 32'h81);
        rd(1'b0, q);
        chk("rx_empty", q, 32'h0);
        rd(1'b1, q);
        chk("rx_drained", q, 32'h12);

        // overrun
        for (int i = 0; i <= 16; i++)
            send(8'(i), 1'b0);
        cyc(4);
        rd(1'b1, q);
        chk("ovr_status", q, 32'h0010_0017);
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, q);
            chk($sformatf("ovr_rd%0d", i), q, i);
        end
        rd(1'b1, q);
        chk("ovr_sticky", q, 32'h16);
        wr(1'b1, 32'h4);
        rd(1'b1, q);
        chk("ovr_clear", q, 32'h12);

        // framing error
        send(8'h55, 1'b1);
        cyc(4);
        rd(1'b1, q);
        chk("ferr_status", q, 32'h1A);
        send(8'h77, 1'b0);
        cyc(4);
        rd(1'b1, q);
        chk("ferr_next", q, 32'h0001_001B);
        rd(1'b0, q);
        chk("ferr_77", q, 32'h77);
        wr(1'b1, 32'h4);

        // rx interrupt
        wr(1'b1, 32'h1);
        cyc(2);
        chk("rxirq_off", {31'b0, irq}, 32'd0);
        send(8'h42, 1'b0);
        cyc(3);
        chk("rxirq_on", {31'b0, irq}, 32'd1);
        rd(1'b0, q);
        chk("rxirq_42", q, 32'h42);
        cyc(2);
        chk("rxirq_clr", {31'b0, irq}, 32'd0);
        wr(1'b1, 32'h0);

        // fill TX FIFO, 18th write dropped
        for (int i = 0; i < 18; i++)
            wr(1'b0, i);
        rd(1'b1, q);
        chk("txfull_status", q, 32'h1000_0000);
        wr(1'b1, 32'h2);
        cyc(2);
        chk("txirq_full", {31'b0, irq}, 32'd0);
        rd(1'b1, q);
        chk("txie_status", q, 32'h1000_0200);
        wr(1'b1, 32'hA);
        rd(1'b1, q);
        chk("flush_status", q, 32'h0000_0202);
        chk("flush_irq", {31'b0, irq}, 32'd1);
        k = 0;
        q = '0;
        while (!q[4] && k < 60) begin
            rd(1'b1, q);
            k++;
        end
        chk("flush_done", q, 32'h0000_0212);
        cyc(30);
        chk("flush_txd", {31'b0, txd}, 32'd1);
        rd(1'b1, q);
        chk("flush_quiet", q, 32'h0000_0212);

        // tx irq rises when last byte leaves the FIFO
        wr(1'b0, 32'h11);
        wr(1'b0, 32'h22);
        cyc(2);
        chk("txirq_pend", {31'b0, irq}, 32'd0);
        k = 0;
        while (!irq && k < 300) begin
            cyc(1);
            k++;
        end
        chk("txirq_rise", {31'b0, irq}, 32'd1);
        rd(1'b1, q);
        chk("txirq_busy", q, 32'h0000_0202);
        cyc(120);
        rd(1'b1, q);
        chk("txirq_idle", q, 32'h0000_0212);
        wr(1'b1, 32'h0);

        // reset mid-character
        wr(1'b0, 32'h00);
        cyc(20);
        chk("mid_txd_lo", {31'b0, txd}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", {31'b0, txd}, 32'd1);
        cyc(3);
        rst_n = 1'b1;
        rd(1'b1, q);
        chk("mid_rst_status", q, 32'h12);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
